// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit: funct3 encodings,
// flush FSM states, predictor counter reset value and the taken decode.
package branch_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV0 = 3'b010;
    localparam logic [2:0] F3_RSV1 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_CTR_RESET = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2
    } state_e;

    // Signed and unsigned variants share the blt input; brun picks the compare.
    function automatic logic br_taken(input logic [2:0] f3, input logic beq, input logic blt);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:           t = beq;
            F3_BNE:           t = !beq;
            F3_BLT, F3_BLTU:  t = blt;
            F3_BGE, F3_BGEU:  t = !blt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic br_reserved(input logic [2:0] f3);
        return (f3 == F3_RSV0) || (f3 == F3_RSV1);
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Table of 2-bit saturating predictor counters, combinational lookup and
// synchronous update; a lookup sees the value before any same-cycle update.
module branch_bht
    import branch_resolve_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_o,
    input  logic        upd_en_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       ctr_q [ENTRIES];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_pc_bits;

    assign lookup_idx     = lookup_pc_i[IDX_W+1:2];
    assign upd_idx        = upd_pc_i[IDX_W+1:2];
    assign pred_o         = ctr_q[lookup_idx][1];
    assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                              upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_CTR_RESET;
            end
        end else if (upd_en_i) begin
            if (upd_taken_i && ctr_q[upd_idx] != 2'd3) begin
                ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
            end else if (!upd_taken_i && ctr_q[upd_idx] != 2'd0) begin
                ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: redirect on mispredict, two-cycle IF/ID flush,
// statistics. Define BRANCH_BHT_EN to add the 2-bit counter predictor.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_jump,
    input  logic [2:0]  funct3,
    input  logic        beq,
    input  logic        blt,
    input  logic [31:0] ex_pc,
    input  logic [31:0] target,
    input  logic        pred_taken,
    input  logic [31:0] fetch_pc,
    output logic        brun,
    output logic        pred_out,
    output logic        pc_sel,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        illegal_br,
    output logic [31:0] taken_cnt,
    output logic [31:0] mispred_cnt
);

    state_e      state_q;
    logic        pc_sel_q;
    logic        flush_q;
    logic        illegal_q;
    logic [31:0] redirect_q;
    logic [31:0] redirect_d;
    logic [31:0] taken_cnt_q;
    logic [31:0] mispred_cnt_q;

    logic resolve;
    logic taken;
    logic mispredict;

    // Instructions arriving while a flush is in progress are already squashed.
    assign resolve    = ex_valid && (state_q == IDLE);
    assign taken      = ex_is_jump || br_taken(funct3, beq, blt);
    assign mispredict = resolve && (taken != pred_taken);
    assign redirect_d = taken ? target : ex_pc + 32'd4;

    assign brun        = funct3[1];
    assign pc_sel      = pc_sel_q;
    assign flush       = flush_q;
    assign illegal_br  = illegal_q;
    assign redirect_pc = redirect_q;
    assign taken_cnt   = taken_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_sel_q      <= 1'b0;
            flush_q       <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_q    <= 32'd0;
            taken_cnt_q   <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            pc_sel_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    flush_q <= 1'b0;
                    if (resolve) begin
                        illegal_q <= !ex_is_jump && br_reserved(funct3);
                        if (taken) begin
                            taken_cnt_q <= taken_cnt_q + 32'd1;
                        end
                        if (mispredict) begin
                            pc_sel_q      <= 1'b1;
                            redirect_q    <= redirect_d;
                            mispred_cnt_q <= mispred_cnt_q + 32'd1;
                            state_q       <= FLUSH1;
                            flush_q       <= 1'b1;
                        end
                    end
                end
                FLUSH1: begin
                    state_q <= FLUSH2;
                    flush_q <= 1'b1;
                end
                FLUSH2: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_BHT_EN
    branch_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_i       (clk),
        .rst_i       (rst),
        .lookup_pc_i (fetch_pc),
        .pred_o      (pred_out),
        .upd_en_i    (resolve && !ex_is_jump),
        .upd_pc_i    (ex_pc),
        .upd_taken_i (taken)
    );
`else
    logic unused_cfg;
    assign pred_out   = 1'b0;
    assign unused_cfg = ^{fetch_pc, 32'(BHT_ENTRIES)};
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve; predictor checks adapt to
// whether BRANCH_BHT_EN is defined.
module tb_branch_resolve;

    logic        clock;
    logic        reset;
    logic        exValid;
    logic        exIsJump;
    logic [2:0]  funct3;
    logic        beq;
    logic        blt;
    logic [31:0] exPc;
    logic [31:0] target;
    logic        predTaken;
    logic [31:0] fetchPc;
    logic        brun;
    logic        predOut;
    logic        pcSel;
    logic [31:0] redirectPc;
    logic        flush;
    logic        illegalBr;
    logic [31:0] takenCnt;
    logic [31:0] mispredCnt;

    int vectorsApplied = 0;
    int miscompares    = 0;

    branch_resolve #(.BHT_ENTRIES(16)) dut (
        .clk         (clock),
        .rst         (reset),
        .ex_valid    (exValid),
        .ex_is_jump  (exIsJump),
        .funct3      (funct3),
        .beq         (beq),
        .blt         (blt),
        .ex_pc       (exPc),
        .target      (target),
        .pred_taken  (predTaken),
        .fetch_pc    (fetchPc),
        .brun        (brun),
        .pred_out    (predOut),
        .pc_sel      (pcSel),
        .redirect_pc (redirectPc),
        .flush       (flush),
        .illegal_br  (illegalBr),
        .taken_cnt   (takenCnt),
        .mispred_cnt (mispredCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic isJump, input logic [2:0] f3,
                                 input logic beqV, input logic bltV, input logic [31:0] pc,
                                 input logic [31:0] tgt, input logic pred);
        exValid   = valid;
        exIsJump  = isJump;
        funct3    = f3;
        beq       = beqV;
        blt       = bltV;
        exPc      = pc;
        target    = tgt;
        predTaken = pred;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        fetchPc = 32'h0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst pc_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("rst flush", {31'd0, flush}, 32'd0);
        checkOutput("rst illegal", {31'd0, illegalBr}, 32'd0);
        checkOutput("rst redirect", redirectPc, 32'd0);
        checkOutput("rst taken_cnt", takenCnt, 32'd0);
        checkOutput("rst mispred_cnt", mispredCnt, 32'd0);
        checkOutput("rst pred_out", {31'd0, predOut}, 32'd0);

        funct3 = 3'b110; #1;
        checkOutput("brun bltu", {31'd0, brun}, 32'd1);
        funct3 = 3'b101; #1;
        checkOutput("brun bge", {31'd0, brun}, 32'd0);

        // BEQ taken but predicted not-taken
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h40, 32'h100, 1'b0);
        tick();
        idle();
        checkOutput("beq pc_sel", {31'd0, pcSel}, 32'd1);
        checkOutput("beq redirect", redirectPc, 32'h100);
        checkOutput("beq flush1", {31'd0, flush}, 32'd1);
        checkOutput("beq taken_cnt", takenCnt, 32'd1);
        checkOutput("beq mispred_cnt", mispredCnt, 32'd1);
        tick();
        checkOutput("beq pc_sel drop", {31'd0, pcSel}, 32'd0);
        checkOutput("beq flush2", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("beq flush end", {31'd0, flush}, 32'd0);

        // BNE correctly predicted taken
        applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 32'h80, 32'h300, 1'b1);
        tick();
        idle();
        checkOutput("bne ok pc_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("bne ok flush", {31'd0, flush}, 32'd0);
        checkOutput("bne ok taken_cnt", takenCnt, 32'd2);
        checkOutput("bne ok mispred_cnt", mispredCnt, 32'd1);

        // BGE not taken, predicted taken, fall-through wraps
        applyStimulus(1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h500, 1'b1);
        tick();
        checkOutput("bge pc_sel", {31'd0, pcSel}, 32'd1);
        checkOutput("bge redirect wrap", redirectPc, 32'h0);
        checkOutput("bge mispred_cnt", mispredCnt, 32'd2);
        checkOutput("bge taken_cnt", takenCnt, 32'd2);

        // Mispredicting branch held in EX through FLUSH1 and FLUSH2 is squashed
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h60, 32'h200, 1'b0);
        tick();
        checkOutput("squash pc_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("squash redirect", redirectPc, 32'h0);
        checkOutput("squash flush", {31'd0, flush}, 32'd1);
        tick();
        idle();
        checkOutput("squash done flush", {31'd0, flush}, 32'd0);
        checkOutput("squash done pc_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("squash taken_cnt", takenCnt, 32'd2);
        checkOutput("squash mispred_cnt", mispredCnt, 32'd2);

        // Reserved funct3
        applyStimulus(1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 32'h70, 32'h700, 1'b0);
        tick();
        idle();
        checkOutput("illegal pulse", {31'd0, illegalBr}, 32'd1);
        checkOutput("illegal pc_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("illegal taken_cnt", takenCnt, 32'd2);
        checkOutput("illegal mispred_cnt", mispredCnt, 32'd2);
        tick();
        checkOutput("illegal drop", {31'd0, illegalBr}, 32'd0);

        // Jump predicted not-taken
        applyStimulus(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 32'h90, 32'h80, 1'b0);
        tick();
        idle();
        checkOutput("jump pc_sel", {31'd0, pcSel}, 32'd1);
        checkOutput("jump redirect", redirectPc, 32'h80);
        checkOutput("jump illegal", {31'd0, illegalBr}, 32'd0);
        checkOutput("jump taken_cnt", takenCnt, 32'd3);
        checkOutput("jump mispred_cnt", mispredCnt, 32'd3);
        tick();
        tick();

        // Reset in FLUSH1 aborts the flush
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h10, 32'h900, 1'b1);
        tick();
        idle();
        checkOutput("pre-rst redirect", redirectPc, 32'h14);
        checkOutput("pre-rst flush", {31'd0, flush}, 32'd1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        fetchPc = 32'h40;
        #1;
        checkOutput("midrst flush", {31'd0, flush}, 32'd0);
        checkOutput("midrst pc_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("midrst taken_cnt", takenCnt, 32'd0);
        checkOutput("midrst mispred_cnt", mispredCnt, 32'd0);
        checkOutput("midrst redirect", redirectPc, 32'd0);
        checkOutput("midrst pred_out", {31'd0, predOut}, 32'd0);

        // Three correctly predicted taken BEQs at 0x40; lookup same entry in the first cycle
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h40, 32'h400, 1'b1);
        #1;
        checkOutput("bht pre-update", {31'd0, predOut}, 32'd0);
        tick();
        tick();
        tick();
        idle();
        checkOutput("bht taken_cnt", takenCnt, 32'd3);
        checkOutput("bht pc_sel", {31'd0, pcSel}, 32'd0);
`ifdef BRANCH_BHT_EN
        checkOutput("bht pred 0x40", {31'd0, predOut}, 32'd1);
`else
        checkOutput("nobht pred 0x40", {31'd0, predOut}, 32'd0);
`endif
        fetchPc = 32'h44;
        #1;
        checkOutput("bht pred 0x44", {31'd0, predOut}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
